// File: rtl/cu_multicycle.sv
// Multicycle control unit: fetches {opc, op1, op2, op3} words, sequences memory loads/stores and
// ALU requests with timeout. Optional illegal-opcode trap is enabled by defining CU_TRAP_EN.
module cu_multicycle #(
    parameter int unsigned REG_SIZE    = 8,
    parameter int unsigned OPC_W       = 4,
    parameter int unsigned ALU_TIMEOUT = 15,
    parameter int unsigned RESET_PC    = 0
`ifdef CU_TRAP_EN
    ,
    parameter int unsigned TRAP_VEC    = 'hF0
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [OPC_W+3*REG_SIZE-1:0] ins_in,
    input  logic                        ins_valid,
    output logic                        ins_ready,
    output logic [REG_SIZE-1:0]         pc,
    output logic                        busy,
    output logic [2:0]                  alu_operation,
    output logic [REG_SIZE-1:0]         alu_op1,
    output logic [REG_SIZE-1:0]         alu_op2,
    output logic                        alu_req,
    input  logic                        alu_done,
    input  logic [REG_SIZE-1:0]         alu_res,
    output logic [REG_SIZE-1:0]         mem_addr,
    output logic                        mem_re,
    output logic                        mem_we,
    output logic [REG_SIZE-1:0]         mem_wdata,
    input  logic [REG_SIZE-1:0]         mem_rdata,
    input  logic                        mem_ack,
    output logic                        err
`ifdef CU_TRAP_EN
    ,
    output logic                        trap
`endif
);

    localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);

    localparam logic [OPC_W-1:0] OpNop = OPC_W'(4'h0);
    localparam logic [OPC_W-1:0] OpJmp = OPC_W'(4'h1);
    localparam logic [OPC_W-1:0] OpAdd = OPC_W'(4'h2);
    localparam logic [OPC_W-1:0] OpSub = OPC_W'(4'h3);
    localparam logic [OPC_W-1:0] OpMul = OPC_W'(4'h4);
    localparam logic [OPC_W-1:0] OpDiv = OPC_W'(4'h5);
    localparam logic [OPC_W-1:0] OpBre = OPC_W'(4'h6);
    localparam logic [OPC_W-1:0] OpMov = OPC_W'(4'h7);
    localparam logic [OPC_W-1:0] OpAnd = OPC_W'(4'h8);
    localparam logic [OPC_W-1:0] OpOrr = OPC_W'(4'h9);
    localparam logic [OPC_W-1:0] OpXor = OPC_W'(4'hA);
    localparam logic [OPC_W-1:0] OpSet = OPC_W'(4'hB);
    localparam logic [OPC_W-1:0] OpClc = OPC_W'(4'hC);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StLoad1,
        StLoad2,
        StExec,
        StAluWait,
        StStore
    } state_e;

    state_e              r_state, w_state_nxt;
    logic [OPC_W-1:0]    r_opc, w_opc_nxt;
    logic [REG_SIZE-1:0] r_op1, w_op1_nxt;
    logic [REG_SIZE-1:0] r_op2, w_op2_nxt;
    logic [REG_SIZE-1:0] r_op3, w_op3_nxt;
    logic [REG_SIZE-1:0] r_a, w_a_nxt;
    logic [REG_SIZE-1:0] r_b, w_b_nxt;
    logic [REG_SIZE-1:0] r_data, w_data_nxt;
    logic [REG_SIZE-1:0] r_addr, w_addr_nxt;
    logic [REG_SIZE-1:0] r_pc, w_pc_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_err, w_err_nxt;
    logic                r_trap, w_trap_nxt;

    logic [REG_SIZE-1:0] w_pc_inc;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_is_alu;
    logic [2:0]          w_alu_code;

    assign w_pc_inc  = r_pc + 1'b1;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_is_alu   = 1'b1;
        w_alu_code = 3'b000;
        case (r_opc)
            OpAdd:   w_alu_code = 3'b000;
            OpSub:   w_alu_code = 3'b001;
            OpMul:   w_alu_code = 3'b010;
            OpDiv:   w_alu_code = 3'b011;
            OpAnd:   w_alu_code = 3'b100;
            OpOrr:   w_alu_code = 3'b101;
            OpXor:   w_alu_code = 3'b110;
            default: w_is_alu   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StFetch;
            r_opc   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_op3   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_addr  <= '0;
            r_pc    <= REG_SIZE'(RESET_PC);
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_opc   <= w_opc_nxt;
            r_op1   <= w_op1_nxt;
            r_op2   <= w_op2_nxt;
            r_op3   <= w_op3_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_data  <= w_data_nxt;
            r_addr  <= w_addr_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_trap  <= w_trap_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_opc_nxt     = r_opc;
        w_op1_nxt     = r_op1;
        w_op2_nxt     = r_op2;
        w_op3_nxt     = r_op3;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_data_nxt    = r_data;
        w_addr_nxt    = r_addr;
        w_pc_nxt      = r_pc;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = 1'b0;
        w_trap_nxt    = 1'b0;
        ins_ready     = 1'b0;
        alu_req       = 1'b0;
        alu_operation = 3'b000;
        alu_op1       = '0;
        alu_op2       = '0;
        mem_addr      = '0;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = '0;

        case (r_state)
            StFetch: begin
                ins_ready = 1'b1;
                if (ins_valid) begin
                    w_opc_nxt   = ins_in[OPC_W+3*REG_SIZE-1 -: OPC_W];
                    w_op1_nxt   = ins_in[3*REG_SIZE-1 -: REG_SIZE];
                    w_op2_nxt   = ins_in[2*REG_SIZE-1 -: REG_SIZE];
                    w_op3_nxt   = ins_in[REG_SIZE-1:0];
                    w_state_nxt = StDecode;
                end
            end
            StDecode: begin
                w_state_nxt = StFetch;
                if (r_opc == OpNop) begin
                    w_pc_nxt = w_pc_inc;
                end else if (r_opc == OpJmp) begin
                    w_pc_nxt = r_op1;
                end else if (r_opc == OpSet) begin
                    w_data_nxt  = r_op2;
                    w_addr_nxt  = r_op1;
                    w_state_nxt = StStore;
                end else if (r_opc == OpClc) begin
                    w_data_nxt  = '0;
                    w_addr_nxt  = r_op1;
                    w_state_nxt = StStore;
                end else if (r_opc == OpMov || r_opc == OpBre || w_is_alu) begin
                    w_state_nxt = StLoad1;
                end else begin
`ifdef CU_TRAP_EN
                    w_pc_nxt   = REG_SIZE'(TRAP_VEC);
                    w_trap_nxt = 1'b1;
`else
                    w_pc_nxt = w_pc_inc;
`endif
                end
            end
            StLoad1: begin
                mem_re   = 1'b1;
                mem_addr = r_op1;
                if (mem_ack) begin
                    w_a_nxt = mem_rdata;
                    if (r_opc == OpMov) begin
                        w_data_nxt  = mem_rdata;
                        w_addr_nxt  = r_op2;
                        w_state_nxt = StStore;
                    end else if (r_opc == OpBre) begin
                        w_pc_nxt    = (mem_rdata != '0) ? r_op2 : w_pc_inc;
                        w_state_nxt = StFetch;
                    end else begin
                        w_state_nxt = StLoad2;
                    end
                end
            end
            StLoad2: begin
                mem_re   = 1'b1;
                mem_addr = r_op2;
                if (mem_ack) begin
                    w_b_nxt     = mem_rdata;
                    w_state_nxt = StExec;
                end
            end
            StExec: begin
                alu_req       = 1'b1;
                alu_op1       = r_a;
                alu_op2       = r_b;
                alu_operation = w_alu_code;
                w_cnt_nxt     = '0;
                w_state_nxt   = StAluWait;
            end
            StAluWait: begin
                alu_op1       = r_a;
                alu_op2       = r_b;
                alu_operation = w_alu_code;
                if (alu_done) begin
                    w_data_nxt  = alu_res;
                    w_addr_nxt  = r_op3;
                    w_state_nxt = StStore;
                end else if (w_cnt_inc == CNT_W'(ALU_TIMEOUT)) begin
                    // Abort: skip the write-back, flag the error and move on.
                    w_err_nxt   = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = StFetch;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            StStore: begin
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_data;
                if (mem_ack) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = StFetch;
                end
            end
            default: w_state_nxt = StFetch;
        endcase
    end

    assign pc   = r_pc;
    assign busy = (r_state != StFetch);
    assign err  = r_err;
`ifdef CU_TRAP_EN
    assign trap = r_trap;
`else
    logic w_unused;
    assign w_unused = r_trap;
`endif

endmodule
